calc_result_collector: RTL and testbench

CALC_RESULT_COLLECTOR -- requirements
Module: calc_result_collector

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_sync_fifo.sv | 84 ++++++++
 rtl/calc_result_collector.sv | 87 ++++++++
 tb/tb_calc_result_collector.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator result path.
//   DATA_W : result word width from the calculator stage
//   SUM_W  : running-sum width
//   CNT_W  : accepted-result counter width
package calc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SUM_W  = 24;
    localparam int unsigned CNT_W  = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam cnt_t CNT_MAX = '1;

    // Statistics register bundle
    typedef struct packed {
        sum_t sum;
        cnt_t cnt;
        logic ovf;
    } stats_t;

    // Increment that holds at the all-ones value
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == CNT_MAX) ? c : cnt_t'(c + 1'b1);
    endfunction

endpackage

// File: rtl/calc_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and no write-to-read bypass.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push_i, wdata_i: write request and data (ignored when full)
//   pop_i          : read request (ignored when empty)
//   rdata_o        : oldest entry (don't-care while empty)
//   full_o, empty_o: registered occupancy flags
module calc_sync_fifo
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i  & ~empty_q;

    // Pointer and occupancy next state; pointers wrap naturally at power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
        end
        if (pop_ok) begin
            rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
        end
        case ({push_ok, pop_ok})
            2'b10:   occ_d = OCC_W'(occ_q + 1'b1);
            2'b01:   occ_d = OCC_W'(occ_q - 1'b1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state; flags are precomputed from next occupancy so they are flop outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            full_q   <= (occ_d == OCC_W'(DEPTH));
            empty_q  <= (occ_d == '0);
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/calc_result_collector.sv
// Collects calculator results into a FIFO for a downstream consumer and keeps
// running statistics (sum, count, sum-overflow) over accepted results.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   inC, iValid, iStall   : upstream result, valid, back-pressure (full)
//   outD, oValid, oStall  : downstream head word, valid, consumer stall
//   clr                   : synchronous clear of statistics only
//   sumOut, cntOut, ovf   : running sum, saturating count, sticky wrap flag
module calc_result_collector
    import calc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inC,
    input  logic              iValid,
    output logic              iStall,
    output logic [DATA_W-1:0] outD,
    output logic              oValid,
    input  logic              oStall,
    input  logic              clr,
    output logic [SUM_W-1:0]  sumOut,
    output logic [CNT_W-1:0]  cntOut,
    output logic              ovf
);

    localparam int unsigned SUM_EXT_W = SUM_W + 1;

    logic   fifo_full, fifo_empty;
    logic   push, pop;
    stats_t stats_q, stats_d;
    logic [SUM_EXT_W-1:0] sum_ext;

    // Handshakes depend only on registered FIFO flags, never on iValid/oStall paths into iStall
    assign push = iValid & ~fifo_full;
    assign pop  = ~fifo_empty & ~oStall;

    calc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (inC),
        .pop_i   (pop),
        .rdata_o (outD),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign iStall = fifo_full;
    assign oValid = ~fifo_empty;

    // Statistics next state; clr wins over accumulation but still counts a same-cycle push
    always_comb begin
        stats_d = stats_q;
        sum_ext = SUM_EXT_W'(stats_q.sum) + SUM_EXT_W'(inC);
        if (clr) begin
            stats_d.sum = '0;
            stats_d.cnt = '0;
            stats_d.ovf = 1'b0;
            if (push) begin
                stats_d.sum = SUM_W'(inC);
                stats_d.cnt = CNT_W'(1);
            end
        end else if (push) begin
            stats_d.sum = sum_ext[SUM_W-1:0];
            stats_d.cnt = cnt_sat_inc(stats_q.cnt);
            stats_d.ovf = stats_q.ovf | sum_ext[SUM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign sumOut = stats_q.sum;
    assign cntOut = stats_q.cnt;
    assign ovf    = stats_q.ovf;

endmodule

// File: tb/tb_calc_result_collector.sv
module tb_calc_result_collector;

    logic        clk;
    logic        rst;
    logic [15:0] inC;
    logic        iValid;
    logic        iStall;
    logic [15:0] outD;
    logic        oValid;
    logic        oStall;
    logic        clr;
    logic [23:0] sumOut;
    logic [7:0]  cntOut;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [15:0] exp_q [$];

    calc_result_collector #(.DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .inC    (inC),
        .iValid (iValid),
        .iStall (iStall),
        .outD   (outD),
        .oValid (oValid),
        .oStall (oStall),
        .clr    (clr),
        .sumOut (sumOut),
        .cntOut (cntOut),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: record the push the DUT is about to accept, then advance past the edge
    task automatic step();
        @(negedge clk);
        if (rst) exp_q.delete();
        else if (iValid && !iStall) exp_q.push_back(inC);
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        iValid = 1'b1;
        inC    = w;
        step();
        iValid = 1'b0;
    endtask

    // Monitor: every word the consumer takes must be the oldest expected word
    always @(negedge clk) begin
        logic [15:0] w;
        if (!rst && oValid && !oStall) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stale_word: got outD=0x%0h, expected no word at %0t", outD, $time);
            end else begin
                w = exp_q.pop_front();
                chk("fifo_order", {16'h0, outD}, {16'h0, w});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst = 1'b1; clr = 1'b0; iValid = 1'b0; inC = '0; oStall = 1'b0;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        chk("rst_ovalid", oValid, 0);
        chk("rst_istall", iStall, 0);
        chk("rst_sum", sumOut, 0);
        chk("rst_cnt", cntOut, 0);
        chk("rst_ovf", ovf, 0);

        // Single word: visible one cycle after push, gone after it is taken
        push_word(16'h0005);
        chk("single_ovalid", oValid, 1);
        chk("single_outd", outD, 16'h0005);
        chk("single_sum", sumOut, 5);
        chk("single_cnt", cntOut, 1);
        step();
        chk("single_ovalid_low", oValid, 0);

        // Fill with consumer stalled; head stays stable
        oStall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("fill_no_stall_before", iStall, 0);
            push_word(16'(i));
            chk("fill_head_stable", outD, 16'h0001);
        end
        chk("fill_istall", iStall, 1);
        push_word(16'h0099);
        chk("fill_rejected_cnt", cntOut, 5);
        chk("fill_rejected_sum", sumOut, 15);
        oStall = 1'b0;
        repeat (5) step();
        chk("drain_ovalid_low", oValid, 0);
        chk("drain_istall_low", iStall, 0);

        // Simultaneous push/pop at occupancy 2
        oStall = 1'b1;
        push_word(16'h0010);
        push_word(16'h0011);
        oStall = 1'b0;
        iValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inC = 16'(16'h0020 + i);
            step();
            chk("simul_no_stall", iStall, 0);
            chk("simul_ovalid", oValid, 1);
        end
        iValid = 1'b0;
        p0 = pops;
        repeat (4) step();
        chk("simul_occupancy_2", pops - p0, 2);
        chk("simul_cnt", cntOut, 17);
        chk("simul_sum", sumOut, 24'h00019D);

        // Sum wrap to 0xFFFFF0 then +0x20
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_sum", sumOut, 0);
        chk("clr_cnt", cntOut, 0);
        iValid = 1'b1;
        inC = 16'hFFFF;
        repeat (256) step();
        inC = 16'h00F0;
        step();
        iValid = 1'b0;
        chk("pre_wrap_sum", sumOut, 24'hFFFFF0);
        chk("pre_wrap_ovf", ovf, 0);
        chk("pre_wrap_cnt", cntOut, 255);
        push_word(16'h0020);
        chk("wrap_sum", sumOut, 24'h000010);
        chk("wrap_ovf", ovf, 1);
        push_word(16'h0001);
        chk("wrap_ovf_sticky", ovf, 1);
        chk("wrap_sum2", sumOut, 24'h000011);
        clr = 1'b1; step(); clr = 1'b0;
        chk("wrap_clr_sum", sumOut, 0);
        chk("wrap_clr_cnt", cntOut, 0);
        chk("wrap_clr_ovf", ovf, 0);
        repeat (3) step();

        // Count saturation, then clr together with a push
        iValid = 1'b1;
        inC = 16'h0001;
        repeat (300) step();
        iValid = 1'b0;
        chk("sat_cnt", cntOut, 255);
        chk("sat_sum", sumOut, 300);
        clr = 1'b1;
        push_word(16'h0007);
        clr = 1'b0;
        chk("clrpush_sum", sumOut, 7);
        chk("clrpush_cnt", cntOut, 1);
        chk("clrpush_ovf", ovf, 0);
        repeat (3) step();

        // Reset with three words held
        oStall = 1'b1;
        push_word(16'h00A1);
        push_word(16'h00A2);
        push_word(16'h00A3);
        chk("held_ovalid", oValid, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_ovalid", oValid, 0);
        chk("midrst_istall", iStall, 0);
        chk("midrst_sum", sumOut, 0);
        chk("midrst_cnt", cntOut, 0);
        chk("midrst_ovf", ovf, 0);
        oStall = 1'b0;
        p0 = pops;
        repeat (5) step();
        chk("midrst_no_emit", pops - p0, 0);
        push_word(16'h0055);
        chk("post_rst_outd", outD, 16'h0055);
        step();
        chk("post_rst_pops", pops - p0, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
